i2c_master: RTL and testbench
=============================

# i2c_master

Byte-oriented I2C master controller that generates the bus traffic consumed by the team's `I2C_slave`. It turns one command (7-bit address, R/W, one data byte) into a complete bus transaction: START, address+R/W, slave ACK check, one data byte (written, or read with master NACK), STOP. It sits between a host register interface and the SCL/SDA pins; at the top level, `SDA = sda_en ? sda_out : 1'bz` with a pull-up.

## Interface
- `CLK_DIV`, 5: clk cycles per SCL quarter-period (≥1). SCL period = 4·CLK_DIV clk cycles.
- `LSB_FIRST`, 1: shift order for address and data bytes. Default 1 matches `I2C_slave`; 0 gives standard MSB-first.
- `clk  in  1`: system clock, the only clock.
- `RESET  in  1`: synchronous, active-high reset.
- `cmd_valid  in  1`: command request.
- `cmd_ready  out  1`: high only in IDLE.
- `cmd_addr  in  7`: slave address.
- `cmd_rw  in  1`: 0 = write, 1 = read.
- `cmd_wdata  in  8`: byte to write.
- `rd_data  out  8`: byte received on read; holds until the next read completes.
- `done  out  1`: one-cycle pulse when STOP completes.
- `ack_err  out  1`: valid with `done`; 1 if any slave ACK slot was NACK.
- `scl_out  out  1`: SCL, push-pull. No clock stretching.
- `sda_out  out  1`: SDA drive value.
- `sda_en  out  1`: 1 = master drives SDA; 0 = released.
- `sda_in  in  1`: sampled SDA.

## Operation
- Reset values: `cmd_ready`=1, `scl_out`=1, `sda_en`=0, `sda_out`=1, `rd_data`=0, `done`=0, `ack_err`=0; FSM in IDLE, quarter counter 0.
- Command acceptance: the command is accepted on the edge where `cmd_valid && cmd_ready`. `cmd_addr`, `cmd_rw` and `cmd_wdata` are registered on that edge. `cmd_valid` is ignored while busy.
- Address byte: `{cmd_addr, cmd_rw}` (e.g. 0x67 write → 0xCE).
- FSM states: IDLE → START → ADDR (8 bits) → ADDR_ACK.
- After ADDR_ACK:
  - slave NACK → STOP with `ack_err`=1.
  - rw=0 → WDATA (8) → WDATA_ACK → STOP.
  - rw=1 → RDATA (8) → RDATA_ACK → STOP.
- In RDATA_ACK the master drives NACK (SDA=1).
- STOP → IDLE.
- SDA ownership: the master drives in START, ADDR, WDATA, RDATA_ACK and STOP. It releases (`sda_en`=0) in ADDR_ACK, WDATA_ACK, RDATA and IDLE.
- `ack_err` is sticky within a transaction and cleared on command accept.

## Timing
- Each state except IDLE lasts bit-times of 4 quarters (q0–q3), each CLK_DIV cycles.
- Data and ACK bits:
  - q0/q1: `scl_out`=0; SDA changes at the start of q0.
  - q2/q3: `scl_out`=1.
  - `sda_in` is sampled on the edge entering q3.
- START bit:
  - q0–q1: SCL=1, SDA=1.
  - q2: SDA→0 while SCL=1.
  - q3: SCL→0.
- STOP bit:
  - q0: SDA=0, SCL=0.
  - q1–q2: SCL=1.
  - q3: SDA→1 while SCL=1.
- Latency: write or read = 20 bit-times = 80·CLK_DIV cycles from accept to the STOP end. Address NACK = 11 bit-times. `done` pulses the cycle after STOP q3 ends; `cmd_ready` rises in the same cycle.
- Back-to-back: a command accepted in the `done` cycle starts START on the next cycle.
- RESET mid-transaction: next cycle all outputs return to reset values, with no STOP generated. The `rd_data` shift register clears, and `done` does not pulse.
- Bit counter: 3 bits, wraps 7→0 on transition to the ACK state.

## Structure
- Shared package `i2c_pkg`:
  - FSM state encoding.
  - `I2C_WRITE`=0, `I2C_READ`=1, `I2C_ACK`=0, `I2C_NACK`=1.
  - Shared with the slave's bench.
- Sub-module `i2c_scl_gen`:
  - CLK_DIV counter plus 2-bit quarter index.
  - Outputs `q_tick` and `quarter`.
  - Enabled only when not IDLE; resets to 0 on entry to START.

## Test plan
- Write: addr=0x67, rw=0, wdata=0xDD, CLK_DIV=5, slave ACKs → SDA bits LSB-first 0,1,1,1,0,0,1,1 then 1,0,1,1,1,0,1,1. `done` at cycle 401 after accept, `ack_err`=0.
- Read: addr=0x67, rw=1, slave returns 0xA5 → `rd_data`=0xA5, master drives SDA=1 in RDATA_ACK, STOP observed, `ack_err`=0.
- Address NACK: bench leaves SDA high in ADDR_ACK → STOP follows immediately, no data phase, `done` after 11 bit-times, `ack_err`=1.
- Busy: `cmd_valid` pulsed mid-transaction with different addr → ignored; the original transaction completes unchanged.
- Reset during ADDR bit 3 → next cycle `scl_out`=1, `sda_en`=0, `cmd_ready`=1. A new write then completes normally.
- Back-to-back write then read with `cmd_valid` held → second START begins the cycle after `done`. Checker confirms the START/STOP SDA-vs-SCL ordering at every transition.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, bus constants,
// and helpers that map (state, quarter, bit) onto SCL/SDA drive.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_STOP
  } state_t;

  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;
  localparam logic I2C_ACK   = 1'b0;
  localparam logic I2C_NACK  = 1'b1;

  typedef struct packed {
    logic scl;
    logic sda;
    logic en;
  } drive_t;

  function automatic logic pick_bit(
    input logic [7:0] b,
    input logic [2:0] i,
    input logic       lsb
  );
    return lsb ? b[i] : b[3'd7 - i];
  endfunction

  // Pin levels for a given state/quarter; b is the data bit
  // shifted out in ADDR/WDATA.
  function automatic drive_t bus_drive(
    input state_t     s,
    input logic [1:0] q,
    input logic       b
  );
    drive_t d;
    d.scl = q[1];
    d.sda = 1'b1;
    d.en  = 1'b0;
    case (s)
      ST_IDLE: d.scl = 1'b1;
      ST_START: begin
        d.scl = (q != 2'd3);
        d.sda = ~q[1];
        d.en  = 1'b1;
      end
      ST_ADDR, ST_WDATA: begin
        d.sda = b;
        d.en  = 1'b1;
      end
      ST_RDATA_ACK: begin
        d.sda = I2C_NACK;
        d.en  = 1'b1;
      end
      ST_STOP: begin
        d.scl = (q != 2'd0);
        d.sda = (q == 2'd3);
        d.en  = 1'b1;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/i2c_scl_gen.sv
// Quarter-period timebase: CLK_DIV divider plus 2-bit quarter index.
// Ports: clk, RESET, i_en (busy) -> q_tick (last cycle of quarter), quarter.
module i2c_scl_gen #(
  parameter int CLK_DIV = 5
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       i_en,
  output logic       q_tick,
  output logic [1:0] quarter
);

  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] DIV_MAX = W'(CLK_DIV - 1);

  logic [W-1:0] r_div;
  logic [1:0]   r_q;

  assign q_tick  = i_en && (r_div == DIV_MAX);
  assign quarter = r_q;

  // Held at zero while idle so every START begins at q0, cycle 0.
  always_ff @(posedge clk) begin
    if (RESET || !i_en) begin
      r_div <= '0;
      r_q   <= 2'd0;
    end else if (q_tick) begin
      r_div <= '0;
      r_q   <= r_q + 2'd1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_master.sv
// Byte-oriented I2C master: START, addr+RW, ACK, one data byte, STOP.
// Ports: cmd_* host request, rd_data/done/ack_err result, scl/sda pins.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int CLK_DIV   = 5,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_wdata,
  output logic [7:0] rd_data,
  output logic       done,
  output logic       ack_err,
  output logic       scl_out,
  output logic       sda_out,
  output logic       sda_en,
  input  logic       sda_in
);

  state_t     r_state;
  state_t     w_nstate;
  logic [2:0] r_bit;
  logic [2:0] w_nbit;
  logic [2:0] w_rd_idx;
  logic [1:0] w_q;
  logic [1:0] w_nq;
  logic [7:0] r_abyte;
  logic [7:0] r_wdata;
  logic [7:0] r_rd_sh;
  logic [7:0] r_rd_data;
  logic       r_rw;
  logic       r_ack_err;
  logic       r_done;
  logic       r_ready;
  logic       r_scl;
  logic       r_sda;
  logic       r_en;
  logic       w_tick;
  logic       w_busy;
  logic       w_accept;
  logic       w_end;
  logic       w_sample;
  logic       w_nbitval;
  drive_t     w_drv;

  assign w_busy = (r_state != ST_IDLE);

  i2c_scl_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_scl_gen (
    .clk    (clk),
    .RESET  (RESET),
    .i_en   (w_busy),
    .q_tick (w_tick),
    .quarter(w_q)
  );

  assign w_accept = cmd_valid && r_ready;
  assign w_end    = w_tick && (w_q == 2'd3);
  assign w_sample = w_tick && (w_q == 2'd2);
  assign w_nq     = w_q + {1'b0, w_tick};
  assign w_rd_idx = LSB_FIRST ? r_bit : 3'd7 - r_bit;

  always_comb begin
    w_nstate = r_state;
    w_nbit   = r_bit;
    case (r_state)
      ST_IDLE:
        if (w_accept) w_nstate = ST_START;
      ST_START:
        if (w_end) w_nstate = ST_ADDR;
      ST_ADDR:
        if (w_end) begin
          w_nbit = r_bit + 3'd1;
          if (r_bit == 3'd7) w_nstate = ST_ADDR_ACK;
        end
      ST_ADDR_ACK:
        if (w_end) begin
          if (r_ack_err)  w_nstate = ST_STOP;
          else if (r_rw)  w_nstate = ST_RDATA;
          else            w_nstate = ST_WDATA;
        end
      ST_WDATA:
        if (w_end) begin
          w_nbit = r_bit + 3'd1;
          if (r_bit == 3'd7) w_nstate = ST_WDATA_ACK;
        end
      ST_RDATA:
        if (w_end) begin
          w_nbit = r_bit + 3'd1;
          if (r_bit == 3'd7) w_nstate = ST_RDATA_ACK;
        end
      ST_WDATA_ACK, ST_RDATA_ACK:
        if (w_end) w_nstate = ST_STOP;
      ST_STOP:
        if (w_end) w_nstate = ST_IDLE;
      default: w_nstate = ST_IDLE;
    endcase
    // Pins are registered, so they are derived from next-cycle state.
    w_nbitval = pick_bit((w_nstate == ST_WDATA) ? r_wdata : r_abyte,
                         w_nbit, LSB_FIRST);
    w_drv = bus_drive(w_nstate, w_nq, w_nbitval);
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_bit     <= 3'd0;
      r_abyte   <= 8'h00;
      r_wdata   <= 8'h00;
      r_rw      <= I2C_WRITE;
      r_rd_sh   <= 8'h00;
      r_rd_data <= 8'h00;
      r_ack_err <= 1'b0;
      r_done    <= 1'b0;
      r_ready   <= 1'b1;
      r_scl     <= 1'b1;
      r_sda     <= 1'b1;
      r_en      <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_bit   <= w_nbit;
      r_done  <= (r_state == ST_STOP) && w_end;
      r_ready <= (w_nstate == ST_IDLE);
      r_scl   <= w_drv.scl;
      r_sda   <= w_drv.sda;
      r_en    <= w_drv.en;
      if (w_accept) begin
        r_abyte   <= {cmd_addr, cmd_rw};
        r_wdata   <= cmd_wdata;
        r_rw      <= cmd_rw;
        r_ack_err <= 1'b0;
      end
      if (w_sample) begin
        if ((r_state == ST_ADDR_ACK || r_state == ST_WDATA_ACK)
            && sda_in == I2C_NACK)
          r_ack_err <= 1'b1;
        if (r_state == ST_RDATA)
          r_rd_sh[w_rd_idx] <= sda_in;
      end
      if (r_state == ST_RDATA && w_end && r_bit == 3'd7)
        r_rd_data <= r_rd_sh;
    end
  end

  assign cmd_ready = r_ready;
  assign rd_data   = r_rd_data;
  assign done      = r_done;
  assign ack_err   = r_ack_err;
  assign scl_out   = r_scl;
  assign sda_out   = r_sda;
  assign sda_en    = r_en;

endmodule

// File: tb/tb_i2c_master.sv
// Scoreboard bench for i2c_master: a behavioural slave on the bus,
// a bus decoder, and a done-driven result checker.
module tb_i2c_master;

  localparam int CD = 5;
  localparam int LAT_FULL = 80 * CD + 1;
  localparam int LAT_NACK = 44 * CD + 1;

  typedef struct {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    logic       ack_addr;
    logic       ack_data;
    logic [7:0] rdata;
  } txn_t;

  typedef struct {
    int         lat;
    logic       ack_err;
    logic [7:0] rd;
  } exp_t;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [6:0] cmd_addr = 7'h00;
  logic       cmd_rw = 1'b0;
  logic [7:0] cmd_wdata = 8'h00;
  logic       cmd_ready;
  logic [7:0] rd_data;
  logic       done;
  logic       ack_err;
  logic       scl_out;
  logic       sda_out;
  logic       sda_en;
  logic       sda_in;
  logic       slave_low = 1'b0;

  assign sda_in = ~((sda_en & ~sda_out) | slave_low);

  i2c_master #(
    .CLK_DIV  (CD),
    .LSB_FIRST(1'b1)
  ) dut (
    .clk      (clk),
    .RESET    (RESET),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr (cmd_addr),
    .cmd_rw   (cmd_rw),
    .cmd_wdata(cmd_wdata),
    .rd_data  (rd_data),
    .done     (done),
    .ack_err  (ack_err),
    .scl_out  (scl_out),
    .sda_out  (sda_out),
    .sda_en   (sda_en),
    .sda_in   (sda_in)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  exp_t exp_q[$];
  txn_t bus_q[$];
  int   acc_q[$];
  logic [7:0] last_rd = 8'h00;

  // Reference model: outcome derived from the transaction description.
  task automatic push_txn(input txn_t t);
    exp_t e;
    e.ack_err = !t.ack_addr || (!t.rw && !t.ack_data);
    if (t.rw && t.ack_addr) last_rd = t.rdata;
    e.rd  = last_rd;
    e.lat = t.ack_addr ? LAT_FULL : LAT_NACK;
    exp_q.push_back(e);
    bus_q.push_back(t);
  endtask

  // ---------------- monitor: slave model, bus decoder, result check
  int   cyc = 0;
  int   n_accept = 0;
  logic abort = 1'b0;
  logic in_txn = 1'b0;
  logic prev_scl = 1'b1;
  logic prev_sda = 1'b1;
  logic contention = 1'b0;
  int   nr = 0;
  int   nf = 0;
  logic bits [1:20];
  txn_t cur;

  function automatic logic bus_now();
    return ~((sda_en & ~sda_out) | slave_low);
  endfunction

  always @(negedge clk) begin
    logic sda;
    logic [7:0] v;
    exp_t e;
    int t0;
    cyc++;
    sda = bus_now();
    if (RESET || abort) begin
      in_txn = 1'b0;
      slave_low = 1'b0;
      prev_scl = scl_out;
      prev_sda = sda;
    end else begin
      if (cmd_valid && cmd_ready) begin
        acc_q.push_back(cyc);
        n_accept++;
      end
      if (done) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          t0 = acc_q.pop_front();
          chk("latency", cyc - t0, e.lat);
          chk("ack_err", ack_err, e.ack_err);
          chk("rd_data", rd_data, e.rd);
          chk("ready_at_done", cmd_ready, 1);
        end
      end
      if (scl_out && prev_scl && !sda && prev_sda) begin
        chk("start_outside_txn", in_txn, 0);
        if (acc_q.size() > 0)
          chk("start_time", cyc - acc_q[0], 2 * CD + 1);
        if (bus_q.size() == 0) begin
          chk("start_unexpected", 1, 0);
        end else begin
          cur = bus_q.pop_front();
          in_txn = 1'b1;
          nr = 0;
          nf = -1;
          contention = 1'b0;
          for (int i = 1; i <= 20; i++) bits[i] = 1'b0;
        end
      end else if (scl_out && prev_scl && sda && !prev_sda) begin
        if (!in_txn) begin
          chk("stop_unexpected", 1, 0);
        end else begin
          chk("bus_rises", nr, cur.ack_addr ? 19 : 10);
          for (int i = 0; i < 8; i++) v[i] = bits[i + 1];
          chk("bus_addr", v, {cur.addr, cur.rw});
          chk("bus_addr_ack", bits[9], !cur.ack_addr);
          if (cur.ack_addr) begin
            for (int i = 0; i < 8; i++) v[i] = bits[i + 10];
            chk("bus_data", v, cur.rw ? cur.rdata : cur.wdata);
            chk("bus_last_ack", bits[18],
                cur.rw ? 1'b1 : !cur.ack_data);
          end
          chk("bus_contention", contention, 0);
          in_txn = 1'b0;
        end
      end else if (scl_out && !prev_scl) begin
        nr++;
        if (in_txn && nr >= 1 && nr <= 20) bits[nr] = sda;
      end else if (!scl_out && prev_scl && in_txn) begin
        nf++;
        slave_low = 1'b0;
        if (nf == 8) begin
          slave_low = cur.ack_addr;
        end else if (nf >= 9 && nf <= 16) begin
          if (cur.rw && cur.ack_addr) slave_low = !cur.rdata[nf - 9];
        end else if (nf == 17) begin
          slave_low = !cur.rw && cur.ack_addr && cur.ack_data;
        end
      end
      if (scl_out && sda_en && sda_out && slave_low) contention = 1'b1;
      prev_scl = scl_out;
      prev_sda = bus_now();
    end
  end

  // ---------------- stimulus
  task automatic drive_cmd(input txn_t t);
    int k;
    k = 0;
    while (!cmd_ready && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
    cmd_valid = 1'b1;
    cmd_addr  = t.addr;
    cmd_rw    = t.rw;
    cmd_wdata = t.wdata;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    if (exp_q.size() != 0) begin
      chk("done_timeout", 0, 1);
      exp_q.delete();
      bus_q.delete();
      acc_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run(input txn_t t);
    push_txn(t);
    drive_cmd(t);
    wait_idle();
  endtask

  function automatic txn_t mk(input logic [6:0] a, input logic rw,
                              input logic [7:0] wd, input logic aa,
                              input logic ad, input logic [7:0] rd);
    txn_t t;
    t.addr = a; t.rw = rw; t.wdata = wd;
    t.ack_addr = aa; t.ack_data = ad; t.rdata = rd;
    return t;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    txn_t t2;
    int k;
    int base;

    repeat (3) @(posedge clk);
    #1 RESET = 1'b0;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_scl", scl_out, 1);
    chk("rst_sda_en", sda_en, 0);
    chk("rst_sda_out", sda_out, 1);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_done", done, 0);
    chk("rst_ack_err", ack_err, 0);

    run(mk(7'h67, 1'b0, 8'hDD, 1'b1, 1'b1, 8'h00));
    run(mk(7'h67, 1'b1, 8'h00, 1'b1, 1'b1, 8'hA5));
    run(mk(7'h67, 1'b0, 8'h3C, 1'b0, 1'b1, 8'h00));
    run(mk(7'h2B, 1'b0, 8'h81, 1'b1, 1'b0, 8'h00));

    // busy: request while a transaction is in flight is ignored
    t = mk(7'h51, 1'b0, 8'h96, 1'b1, 1'b1, 8'h00);
    push_txn(t);
    drive_cmd(t);
    repeat (100) @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_addr  = 7'h12;
    cmd_rw    = 1'b1;
    cmd_wdata = 8'h00;
    chk("busy_ready", cmd_ready, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_idle();

    // reset in the middle of the address byte
    t = mk(7'h67, 1'b0, 8'h5A, 1'b1, 1'b1, 8'h00);
    push_txn(t);
    drive_cmd(t);
    k = 0;
    while (!(in_txn && nr == 3) && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    chk("reach_addr_bit3", nr, 3);
    repeat (2) @(posedge clk);
    #1;
    abort = 1'b1;
    RESET = 1'b1;
    @(posedge clk); #1;
    RESET = 1'b0;
    chk("mid_rst_scl", scl_out, 1);
    chk("mid_rst_sda_en", sda_en, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_rd_data", rd_data, 0);
    chk("mid_rst_done", done, 0);
    exp_q.delete();
    bus_q.delete();
    acc_q.delete();
    last_rd = 8'h00;
    @(posedge clk); #1;
    abort = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    run(mk(7'h67, 1'b0, 8'hC3, 1'b1, 1'b1, 8'h00));

    // back-to-back: write, then read held valid across done
    t  = mk(7'h1E, 1'b0, 8'h47, 1'b1, 1'b1, 8'h00);
    t2 = mk(7'h70, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3B);
    push_txn(t);
    push_txn(t2);
    drive_cmd(t);
    base = n_accept;
    cmd_valid = 1'b1;
    cmd_addr  = t2.addr;
    cmd_rw    = t2.rw;
    cmd_wdata = t2.wdata;
    k = 0;
    while (n_accept == base && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    cmd_valid = 1'b0;
    chk("b2b_accepted", n_accept - base, 1);
    wait_idle();

    for (int i = 0; i < 12; i++) begin
      t = mk(7'($urandom), 1'($urandom), 8'($urandom),
             ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) != 0),
             8'($urandom));
      run(t);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
